// File: rtl/pipelined_adder_unit_if.sv
// Handshake bundle for pipelined_adder_unit: operand/op input channel with
// valid/ready, and result output channel with valid/ready.
// master: the stimulus/driver side; slave: the adder unit.
`timescale 1ns/1ps

interface pipelined_adder_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   c;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a,
        output b,
        output op,
        output in_valid,
        input  in_ready,
        input  c,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  a,
        input  b,
        input  op,
        input  in_valid,
        output in_ready,
        output c,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/pipelined_adder_unit.sv
// Pipelined add/sub/accumulate unit with valid/ready on both sides.
// The result is computed when a transaction is accepted and then travels
// through STAGES register stages; a single global stall freezes the whole
// pipe while the output is valid and not taken.
// Optional feature: define ADDER_OVF_EN to add the sticky accumulator
// overflow flag output ovf.
`timescale 1ns/1ps

module pipelined_adder_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pipelined_adder_unit_if.slave bus
`ifdef ADDER_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int RW = WIDTH + 1;

    logic [STAGES-1:0] stage_valid;
    logic [RW-1:0]     stage_data [STAGES];
    logic [RW-1:0]     acc;
    logic [RW-1:0]     acc_sum;
    logic [RW-1:0]     acc_next;
    logic [RW-1:0]     result;
    logic              advance;
    logic              accept;

    // Global stall, accept qualification and the accept-time result.
    // acc is updated here at accept so accumulate chains need no forwarding.
    always_comb begin
        advance  = !stage_valid[STAGES-1] || bus.out_ready;
        accept   = bus.in_valid && advance;
        acc_sum  = acc + {1'b0, bus.a};
        acc_next = acc;
        result   = '0;
        case (bus.op)
            2'b00: result = {1'b0, bus.a} + {1'b0, bus.b};
            2'b01: result = {1'b0, bus.a} - {1'b0, bus.b};
            2'b10: begin
                acc_next = acc_sum;
                result   = acc_sum;
            end
            2'b11: begin
                acc_next = {1'b0, bus.a};
                result   = {1'b0, bus.a};
            end
            default: result = '0;
        endcase
    end

    assign bus.in_ready  = advance;
    assign bus.c         = stage_data[STAGES-1];
    assign bus.out_valid = stage_valid[STAGES-1];

    // Pipeline shift: stage 0 takes the new result (or a bubble), the rest
    // move down one place; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else if (advance) begin
            stage_valid[0] <= accept;
            stage_data[0]  <= result;
            for (int i = 1; i < STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    // Accumulator: only accumulate and load ops touch it, and only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (accept && bus.op[1]) begin
            acc <= acc_next;
        end
    end

`ifdef ADDER_OVF_EN
    logic acc_wrap;

    // A modular sum smaller than the old acc means the add carried out.
    assign acc_wrap = (acc_sum < acc);

    // Sticky overflow: set by a wrapping accumulate, cleared by a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (accept && (bus.op == 2'b10) && acc_wrap) begin
            ovf <= 1'b1;
        end else if (accept && (bus.op == 2'b11)) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder_unit.sv
// Directed bench for pipelined_adder_unit (WIDTH=8, STAGES=2).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. A monitor checks every transfer against a queue of
// hand-computed expected results.
`timescale 1ns/1ps

module tb_pipelined_adder_unit;
    localparam int W = 8;
    localparam int S = 2;

    logic clk = 1'b0;
    logic reset;
`ifdef ADDER_OVF_EN
    logic ovf;
`endif

    always #5 clk = ~clk;

    pipelined_adder_unit_if #(.WIDTH(W)) bus ();

    pipelined_adder_unit #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // One accepted transaction; caller knows in_ready is high this cycle.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [8:0] exp);
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.in_valid = 1'b1;
        exp_q.push_back(exp);
        neg();
        chk("send_ready", 32'(bus.in_ready), 32'd1);
        cyc();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            neg();
            cyc();
        end
    endtask

    // Transfer monitor: every result taken must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0)
                    chk("extra_output", 32'(exp_q.size()), 32'd1);
                else
                    chk("out_order", 32'(bus.c), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = 2'b00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        neg();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_c", 32'(bus.c), 32'd0);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        cyc();

        // Add with latency check: valid exactly 2 cycles after accept, one cycle wide.
        bus.a = 8'd200; bus.b = 8'd100; bus.op = 2'b00; bus.in_valid = 1'b1;
        exp_q.push_back(9'h12C);
        neg();
        chk("add_accept", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        neg();
        chk("add_lat1_valid", 32'(bus.out_valid), 32'd0);
        cyc();
        neg();
        chk("add_lat2_valid", 32'(bus.out_valid), 32'd1);
        chk("add_c", 32'(bus.c), 32'h12C);
        cyc();
        neg();
        chk("add_one_shot", 32'(bus.out_valid), 32'd0);
        cyc();

        // Subtract with and without borrow.
        send(8'd5, 8'd7, 2'b01, 9'h1FE);
        send(8'd7, 8'd5, 2'b01, 9'h002);
        idle(3);

        // Accumulate chains at full rate, including a wrap.
        send(8'd10,  8'd0, 2'b11, 9'd10);
        send(8'd250, 8'd0, 2'b10, 9'd260);
        send(8'd5,   8'd0, 2'b10, 9'd265);
        send(8'd255, 8'd0, 2'b11, 9'd255);
        send(8'd255, 8'd0, 2'b10, 9'd510);
        send(8'd255, 8'd0, 2'b10, 9'h0FD);
        bus.in_valid = 1'b0;
        neg();
`ifdef ADDER_OVF_EN
        chk("ovf_set", 32'(ovf), 32'd1);
`endif
        cyc();
        send(8'd7, 8'd0, 2'b11, 9'd7);
        bus.in_valid = 1'b0;
        neg();
`ifdef ADDER_OVF_EN
        chk("ovf_clear", 32'(ovf), 32'd0);
`endif
        cyc();
        idle(3);

        // Backpressure: consumer stalls, pipe fills, nothing lost.
        bus.out_ready = 1'b0;
        exp_q.push_back(9'd2);
        exp_q.push_back(9'd4);
        exp_q.push_back(9'd6);
        exp_q.push_back(9'd8);
        bus.a = 8'd1; bus.b = 8'd1; bus.op = 2'b00; bus.in_valid = 1'b1;
        neg();
        chk("bp_ready0", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.a = 8'd2; bus.b = 8'd2;
        neg();
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.a = 8'd3; bus.b = 8'd3;
        for (int j = 0; j < 3; j++) begin
            neg();
            chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stall_c", 32'(bus.c), 32'd2);
            cyc();
        end
        bus.out_ready = 1'b1;
        neg();
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.a = 8'd4; bus.b = 8'd4;
        neg();
        chk("bp_last_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        idle(4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation: in-flight results and acc are discarded.
        bus.out_ready = 1'b0;
        bus.a = 8'd40; bus.b = 8'd0; bus.op = 2'b11; bus.in_valid = 1'b1;
        neg();
        cyc();
        bus.a = 8'd1; bus.b = 8'd1; bus.op = 2'b00;
        neg();
        cyc();
        bus.in_valid = 1'b0;
        neg();
        chk("pre_rst_acc", 32'(dut.acc), 32'd40);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        reset = 1'b1;
        neg();
        cyc();
        reset = 1'b0;
        neg();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_acc", 32'(dut.acc), 32'd0);
        chk("mid_rst_c", 32'(bus.c), 32'd0);
        cyc();
        bus.out_ready = 1'b1;
        send(8'd3, 8'd0, 2'b10, 9'd3);
        idle(4);

        // Streaming: simultaneous transfer and accept, no bubbles.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                bus.a = 8'(i); bus.b = 8'(i); bus.op = 2'b00; bus.in_valid = 1'b1;
                exp_q.push_back(9'(2 * i));
            end else begin
                bus.in_valid = 1'b0;
            end
            neg();
            if (i < 16)
                chk("stream_ready", 32'(bus.in_ready), 32'd1);
            if (i >= 2) begin
                chk("stream_valid", 32'(bus.out_valid), 32'd1);
                chk("stream_c", 32'(bus.c), 32'(2 * (i - 2)));
            end
            cyc();
        end
        bus.in_valid = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            cyc();
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/pipelined_adder_unit.md
Name: pipelined_adder_unit

Overview:
- Parametrised, pipelined successor to the single-cycle adder.
- Performs add, subtract, accumulate or load-accumulator on WIDTH-bit unsigned operands.
- Uses a valid/ready handshake on input and output, with full backpressure.
- Sits between the stimulus/driver interface and downstream consumers. The result keeps the carry/borrow bit (WIDTH+1 bits).

Parameters:
- WIDTH, 8, operand width in bits; result is WIDTH+1 bits.
- STAGES, 2, pipeline depth = accept-to-output latency in cycles; legal range 1..8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for op 10 and 11).
- op  input  2  00 = add, 01 = sub, 10 = accumulate, 11 = load accumulator.
- in_valid  input  1  input transaction present.
- in_ready  output  1  unit can accept this cycle.
- c  output  WIDTH+1  result.
- out_valid  output  1  c holds a valid result.
- out_ready  input  1  consumer accepts c this cycle.

Behaviour:
- Reset (synchronous, active-high, sampled on clk): all stage valid bits 0, all stage data 0, acc 0, c 0, out_valid 0. in_ready is 1 the cycle after reset deasserts.
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational).
- On advance, every stage shifts by one. Stage 0 loads {in_valid && in_ready, result}; a bubble inserts a valid=0 entry.
- When advance=0, all stages and acc hold; c and out_valid stay stable until the transfer.
- Latency: with out_ready held at 1, a result accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles from accept to transfer.
- Throughput: one transaction per cycle when not stalled.
- Result computed at accept, zero-extended to WIDTH+1:
  - 00: a + b.
  - 01: (a - b) mod 2^(WIDTH+1); MSB = borrow.
  - 10: acc_next = (acc + a) mod 2^(WIDTH+1); result = acc_next.
  - 11: acc_next = a; result = a.
- acc updates only on accept with op 10 or 11; ops 00 and 01 leave acc unchanged.
- Accumulate chains are hazard-free at full rate because acc is updated at accept, not at output.
- in_valid=1 with in_ready=0: nothing accepted, acc unchanged; the source must hold a, b and op.
- Transfer and accept in the same cycle is legal: the pipeline shifts and no data is lost.
- Reset mid-operation discards all in-flight results and clears acc. out_valid is 0 the cycle after reset is sampled.
- Ordering: outputs leave in strict accept order. There is no reordering and no drop under any out_ready pattern.

Optional Feature:
- Macro ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), a sticky flag.
  - Set when an op-10 accept wraps acc past 2^(WIDTH+1)-1.
  - Cleared by reset or by an op-11 accept.
  - Updated at accept time, not aligned to c.
  - Reset value 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, STAGES=2):
- Add: accept a=200, b=100, op=00 with out_ready=1 -> c=9'h12C, out_valid=1 exactly 2 cycles after accept, for one cycle.
- Sub: a=5, b=7, op=01 -> c=9'h1FE. Then a=7, b=5 -> c=9'h002.
- Accumulate: back-to-back a=10/op=11, a=250/op=10, a=5/op=10 -> c = 10, 260, 265 on consecutive cycles.
  - Then a=255/op=11, then a=255/op=10 twice -> 255, 510, 9'h0FD.
  - With ADDER_OVF_EN, ovf=1 after the wrap; a following op=11 clears it.
- Backpressure: 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 3 cycles -> in_ready drops once both stages are full; c holds 2 stable; after release, outputs are 2, 4, 6, 8 in order with none lost.
- Reset mid-op: 2 transactions in flight plus acc=40, assert reset for 1 cycle -> next cycle out_valid=0 and acc=0; a following op=10 with a=3 yields c=3.
- Simultaneous transfer and accept: continuous in_valid and out_ready=1 for 16 adds a=i, b=i -> 16 outputs 2*i on 16 consecutive cycles, no bubbles.
